// File: rtl/fp_pkg.sv
// Shared floating-point types and constants for the fp16 datapath blocks.
//   fp16_t / fp32_t : packed IEEE-754 binary16 / binary32 layouts
//   fp_class_e      : operand class produced by classification
//   fp16_class()    : classify an fp16 operand from its exponent and mantissa
package fp_pkg;

  typedef struct packed {
    logic       sign;
    logic [4:0] exp;
    logic [9:0] mant;
  } fp16_t;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] mant;
  } fp32_t;

  typedef enum logic [2:0] {
    ZERO = 3'd0,
    SUB  = 3'd1,
    NORM = 3'd2,
    INF  = 3'd3,
    NAN  = 3'd4
  } fp_class_e;

  localparam int          FP16_BIAS          = 15;
  localparam int          FP32_BIAS          = 127;
  localparam logic [7:0]  FP16_TO_FP32_EBIAS = 8'd112;
  localparam logic [31:0] FP32_QNAN          = 32'h7FC00000;

  function automatic fp_class_e fp16_class(input fp16_t h);
    fp_class_e c;
    if (h.exp == 5'd0)       c = (h.mant == 10'd0) ? ZERO : SUB;
    else if (h.exp == 5'h1F) c = (h.mant == 10'd0) ? INF : NAN;
    else                     c = NORM;
    return c;
  endfunction

endpackage

// File: rtl/fp_lzc.sv
// Combinational leading-zero counter.
//   d   : input vector, bit W-1 is the most significant
//   cnt : number of zeros above the highest set bit; W when d is all zero
module fp_lzc #(
  parameter int W = 10
) (
  input  logic [W-1:0]             d,
  output logic [$clog2(W+1)-1:0]   cnt
);

  localparam int CW = $clog2(W + 1);

  // Scan upward so the highest set bit is the last one to write cnt.
  always_comb begin
    cnt = CW'(W);
    for (int i = 0; i < W; i++) begin
      if (d[i]) cnt = CW'(W - 1 - i);
    end
  end

endmodule

// File: rtl/fp16_to_fp32_stream.sv
// Streaming fp16 -> fp32 widening converter, two-stage elastic pipeline.
// Stage 1 registers the operand with its class and leading-zero count;
// stage 2 packs the fp32 word and flags straight into the output registers.
//   clk, rst_n          : clock (rising edge), async active-low reset
//   in_valid/in_ready   : input handshake, in_data is {sign, exp[4:0], mant[9:0]}
//   out_valid/out_ready : output handshake
//   out_data            : fp32 result
//   out_flags           : {is_nan, is_inf, was_subnormal} of the input
//
// Handshake: a beat moves when valid && ready at a rising clk edge. A raised
// valid holds, with its data, until it is taken. in_ready depends only on
// pipeline occupancy and out_ready, never on in_valid.
module fp16_to_fp32_stream
  import fp_pkg::*;
#(
  parameter int EXP_LEN   = 5,
  parameter int MANT_LEN  = 10,
  parameter int FTZ_EN    = 0,
  parameter int CANON_NAN = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [2:0]  out_flags
);

  if (EXP_LEN != 5 || MANT_LEN != 10) begin : g_bad_format
    $error("fp16_to_fp32_stream supports only EXP_LEN=5 and MANT_LEN=10");
  end

  fp16_t      in_h;
  logic [3:0] lz_c;

  // ready_en keeps in_ready low until the first edge after reset release.
  logic       ready_en;
  logic       s1_valid;
  logic       s1_sign;
  logic [4:0] s1_exp;
  logic [9:0] s1_mant;
  fp_class_e  s1_class;
  logic [3:0] s1_lz;

  logic       s1_adv, s2_adv, s2_free;

  fp32_t      pk_data;
  logic [2:0] pk_flags;
  logic [9:0] sub_mant;

  assign in_h = fp16_t'(in_data);

  fp_lzc #(.W(10)) u_lzc (
    .d   (in_h.mant),
    .cnt (lz_c)
  );

  assign s2_adv   = out_valid & out_ready;
  assign s2_free  = ~out_valid | s2_adv;
  assign s1_adv   = s1_valid & s2_free;
  assign in_ready = ready_en & (~s1_valid | s1_adv);

  // Shifting out lz+1 bits drops the leading one, leaving the fraction.
  assign sub_mant = s1_mant << (s1_lz + 4'd1);

  always_comb begin
    pk_data  = '0;
    pk_flags = {s1_class == NAN, s1_class == INF, s1_class == SUB};
    pk_data.sign = s1_sign;
    case (s1_class)
      NORM: begin
        pk_data.exp  = {3'b000, s1_exp} + FP16_TO_FP32_EBIAS;
        pk_data.mant = {s1_mant, 13'b0};
      end
      SUB: begin
        if (FTZ_EN == 0) begin
          pk_data.exp  = FP16_TO_FP32_EBIAS - {4'b0000, s1_lz};
          pk_data.mant = {sub_mant, 13'b0};
        end
      end
      INF: begin
        pk_data.exp = 8'hFF;
      end
      NAN: begin
        pk_data.exp = 8'hFF;
        if (CANON_NAN != 0) pk_data.mant = FP32_QNAN[22:0];
        else                pk_data.mant = {1'b1, s1_mant[8:0], 13'b0};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_en  <= 1'b0;
      s1_valid  <= 1'b0;
      s1_sign   <= 1'b0;
      s1_exp    <= '0;
      s1_mant   <= '0;
      s1_class  <= ZERO;
      s1_lz     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_flags <= '0;
    end else begin
      ready_en <= 1'b1;
      if (in_ready) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_sign  <= in_h.sign;
          s1_exp   <= in_h.exp;
          s1_mant  <= in_h.mant;
          s1_class <= fp16_class(in_h);
          s1_lz    <= lz_c;
        end
      end
      if (s2_free) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          out_data  <= pk_data;
          out_flags <= pk_flags;
        end
      end
    end
  end

endmodule

// File: tb/tb_fp16_to_fp32_stream.sv
module tb_fp16_to_fp32_stream;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        in_valid;
  logic [15:0] in_data;
  logic        dir_ready, rnd_ready, rand_mode;
  logic        out_ready;
  assign out_ready = rand_mode ? rnd_ready : dir_ready;

  logic        in_ready0, out_valid0, in_ready1, out_valid1;
  logic [31:0] out_data0, out_data1;
  logic [2:0]  out_flags0, out_flags1;

  fp16_to_fp32_stream #(.FTZ_EN(0), .CANON_NAN(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
    .in_data(in_data), .out_valid(out_valid0), .out_ready(out_ready),
    .out_data(out_data0), .out_flags(out_flags0));

  fp16_to_fp32_stream #(.FTZ_EN(1), .CANON_NAN(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
    .in_data(in_data), .out_valid(out_valid1), .out_ready(out_ready),
    .out_data(out_data1), .out_flags(out_flags1));

  // ---------------- reference model ----------------
  // Returns {flags, fp32}. Finite values are computed as real numbers and
  // re-encoded from the double-precision bit pattern.
  function automatic logic [34:0] ref_conv(input logic [15:0] h, input bit ftz, input bit canon);
    logic        s;
    int          e, m, de;
    real         v;
    logic [63:0] b;
    s = h[15];
    e = int'(h[14:10]);
    m = int'(h[9:0]);
    if (e == 31) begin
      if (m == 0) return {3'b010, s, 8'hFF, 23'h0};
      if (canon)  return {3'b100, s, 8'hFF, 23'h400000};
      return {3'b100, s, 8'hFF, 1'b1, h[8:0], 13'h0};
    end
    if (e == 0 && m == 0) return {3'b000, s, 31'h0};
    if (e == 0 && ftz)    return {3'b001, s, 31'h0};
    if (e == 0) v = real'(m) * (2.0 ** (-24));
    else        v = real'(1024 + m) * (2.0 ** (e - 25));
    b  = $realtobits(v);
    de = int'(b[62:52]) - 1023 + 127;
    return {2'b00, (e == 0), s, de[7:0], b[51:29]};
  endfunction

  // ---------------- scoreboard ----------------
  logic [34:0] exp_q0[$];
  logic [34:0] exp_q1[$];
  int          ts_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          rel_edges;
  bit          full_rate = 0;
  bit          stall_prev = 0;
  logic [34:0] prev_out;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) rel_edges <= 0;
    else if (rel_edges < 2) rel_edges <= rel_edges + 1;
  end

  // Compare process: sampled mid-cycle, describing the transfer at the next edge.
  always @(negedge clk) begin
    logic [34:0] e;
    bit          exp_rdy;
    int          t;
    cyc++;
    if (!rst_n) begin
      exp_q0.delete();
      exp_q1.delete();
      ts_q.delete();
      stall_prev = 0;
    end else begin
      exp_rdy = (rel_edges >= 1) && (exp_q0.size() < 2 || out_ready);
      check("in_ready0", in_ready0, exp_rdy);
      check("in_ready1", in_ready1, exp_rdy);
      if (stall_prev) check("hold0", {out_valid0, out_flags0, out_data0}, {1'b1, prev_out});
      stall_prev = out_valid0 && !out_ready;
      prev_out   = {out_flags0, out_data0};
      if (out_valid0 && out_ready) begin
        if (exp_q0.size() == 0) check("spurious0", 1, 0);
        else begin
          e = exp_q0.pop_front();
          t = ts_q.pop_front();
          check("data0", {out_flags0, out_data0}, e);
          if (full_rate) check("latency0", cyc - t, 2);
        end
      end
      if (out_valid1 && out_ready) begin
        if (exp_q1.size() == 0) check("spurious1", 1, 0);
        else begin
          e = exp_q1.pop_front();
          check("data1", {out_flags1, out_data1}, e);
        end
      end
      if (in_valid && in_ready0) begin
        exp_q0.push_back(ref_conv(in_data, 1'b0, 1'b0));
        exp_q1.push_back(ref_conv(in_data, 1'b1, 1'b1));
        ts_q.push_back(cyc);
      end
    end
  end

  // Random backpressure source.
  initial begin
    rnd_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1 rnd_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [15:0] d);
    bit acc;
    int k;
    in_valid = 1'b1;
    in_data  = d;
    k = 0;
    do begin
      @(negedge clk);
      acc = in_ready0;
      @(posedge clk);
      #1;
      k++;
    end while (!acc && k < 200);
    if (!acc) check("send_timeout", 1, 0);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((exp_q0.size() != 0 || exp_q1.size() != 0) && k < 400) begin
      @(posedge clk);
      k++;
    end
    #1;
    check("drain_left", exp_q0.size() + exp_q1.size(), 0);
  endtask

  // ---------------- stimulus ----------------
  logic [15:0] dir_vec[14] = '{16'h3C00, 16'hC000, 16'h7BFF, 16'h0001, 16'h03FF,
                               16'h8200, 16'h0000, 16'h8000, 16'h7C00, 16'hFC00,
                               16'h7C01, 16'hFE55, 16'h0155, 16'h8001};
  logic [15:0] bp_in[4]  = '{16'h3C00, 16'h4000, 16'h4200, 16'h4400};
  logic [31:0] bp_exp[4] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};

  initial begin
    int  idx, acc, n_out, first_c, last_c;
    bit  acc_now;

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0;
    dir_ready = 1'b1; rand_mode = 1'b0;

    // Hand-computed expectations pinning the model.
    check("m_3c00", ref_conv(16'h3C00, 0, 0), {3'b000, 32'h3F800000});
    check("m_c000", ref_conv(16'hC000, 0, 0), {3'b000, 32'hC0000000});
    check("m_7bff", ref_conv(16'h7BFF, 0, 0), {3'b000, 32'h477FE000});
    check("m_0001", ref_conv(16'h0001, 0, 0), {3'b001, 32'h33800000});
    check("m_03ff", ref_conv(16'h03FF, 0, 0), {3'b001, 32'h387FC000});
    check("m_8200", ref_conv(16'h8200, 0, 0), {3'b001, 32'hB8000000});
    check("m_0001_ftz", ref_conv(16'h0001, 1, 1), {3'b001, 32'h00000000});
    check("m_8000", ref_conv(16'h8000, 0, 0), {3'b000, 32'h80000000});
    check("m_fc00", ref_conv(16'hFC00, 0, 0), {3'b010, 32'hFF800000});
    check("m_7c01", ref_conv(16'h7C01, 0, 0), {3'b100, 32'h7FC02000});
    check("m_7c01_canon", ref_conv(16'h7C01, 1, 1), {3'b100, 32'h7FC00000});

    // Reset state.
    #1;
    check("rst_out_valid", out_valid0, 1'b0);
    check("rst_out_data", out_data0, 32'h0);
    check("rst_out_flags", out_flags0, 3'b000);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Directed vectors and exhaustive sweep at full rate.
    full_rate = 1;
    foreach (dir_vec[i]) send(dir_vec[i]);
    for (int v = 0; v < 65536; v++) send(16'(v));
    drain();
    full_rate = 0;

    // Backpressure: output blocked for 6 cycles.
    dir_ready = 1'b0;
    idx = 0; acc = 0;
    in_valid = 1'b1; in_data = bp_in[0];
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      acc_now = in_valid && in_ready0;
      @(posedge clk);
      #1;
      if (acc_now) begin
        acc++; idx++;
        if (idx < 4) in_data = bp_in[idx]; else in_valid = 1'b0;
      end
    end
    check("bp_accepts", acc, 2);
    @(negedge clk);
    check("bp_in_ready_low", in_ready0, 1'b0);
    @(posedge clk);
    #1 dir_ready = 1'b1;
    n_out = 0; first_c = 0; last_c = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (out_valid0 && n_out < 4) begin
        check("bp_data", out_data0, bp_exp[n_out]);
        if (n_out == 0) first_c = c;
        last_c = c;
        n_out++;
      end
      acc_now = in_valid && in_ready0;
      @(posedge clk);
      #1;
      if (acc_now) begin
        idx++;
        if (idx < 4) in_data = bp_in[idx]; else in_valid = 1'b0;
      end
    end
    check("bp_count", n_out, 4);
    check("bp_no_gaps", last_c - first_c, 3);
    drain();

    // Reset with both stages occupied.
    dir_ready = 1'b0;
    send(16'h3C00);
    send(16'h4000);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_valid0", out_valid0, 1'b0);
    check("midrst_valid1", out_valid1, 1'b0);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    dir_ready = 1'b1;
    send(16'h4500);
    drain();

    // Randomized traffic with random backpressure.
    rand_mode = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      send(16'($urandom_range(0, 65535)));
    end
    drain();
    rand_mode = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
